estagio_busca: RTL



---
 rtl/redux_pkg.sv | 9 +
 rtl/estagio_busca_registrador_pc.sv | 21 ++
 rtl/estagio_busca.sv | 75 +++++++
 3 files changed

// File: rtl/redux_pkg.sv
// redux_pkg: shared widths and fetch-stage state encoding for the Redux-V core.
package redux_pkg;
    localparam int LARG_END   = 8;
    localparam int LARG_INSTR = 8;
    typedef enum logic [1:0] {
        BUSCA  = 2'b00,
        PARADO = 2'b01
    } estado_t;
endpackage

// File: rtl/estagio_busca_registrador_pc.sv
// registrador_pc: program counter register with async reset to the start address and a load enable.
module registrador_pc
    import redux_pkg::*;
#(
    parameter int                  LARG_PC = redux_pkg::LARG_END,
    parameter logic [LARG_PC-1:0]  PC_INICIAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_carga,
    input  logic [LARG_PC-1:0] i_valor,
    output logic [LARG_PC-1:0] o_valor
);
    logic [LARG_PC-1:0] r_valor;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_valor <= PC_INICIAL;
        else if (i_carga) r_valor <= i_valor;

    assign o_valor = r_valor;
endmodule

// File: rtl/estagio_busca.sv
// estagio_busca: instruction fetch stage; owns the PC, registers the fetched word and
// offers it to decode over valid/ready, with branch redirect/flush and halt after the last address.
module estagio_busca
    import redux_pkg::*;
#(
    parameter int                    LARG_E      = redux_pkg::LARG_END,
    parameter int                    LARG_I      = redux_pkg::LARG_INSTR,
    parameter logic [LARG_E-1:0]     END_INICIAL = '0,
    parameter logic [LARG_E-1:0]     ULTIMO_END  = 8'd101
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LARG_E-1:0] endereco,
    input  logic [LARG_I-1:0] instrucao_mem,
    output logic [LARG_I-1:0] instrucao,
    output logic [LARG_E-1:0] pc_instrucao,
    output logic              valida,
    input  logic              pronto,
    input  logic              desvio,
    input  logic [LARG_E-1:0] alvo_desvio,
    output logic              parado
);
    estado_t           r_estado;
    logic [LARG_I-1:0] r_instrucao;
    logic [LARG_E-1:0] r_pc_instrucao;
    logic              r_valida;
    logic              w_transfer;
    logic              w_livre;
    logic              w_buscando;
    logic              w_ultimo;
    logic              w_carga_pc;
    logic [LARG_E-1:0] w_prox_pc;

    assign w_transfer = r_valida & pronto;
    assign w_livre    = ~r_valida | w_transfer;
    // Spare state codes behave as BUSCA so the stage can never lock up.
    assign w_buscando = r_estado != PARADO;
    assign w_ultimo   = endereco == ULTIMO_END;
    assign w_carga_pc = desvio | (w_buscando & w_livre & ~w_ultimo);
    assign w_prox_pc  = desvio ? alvo_desvio : endereco + 1'b1;

    registrador_pc #(.LARG_PC(LARG_E), .PC_INICIAL(END_INICIAL)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .i_carga(w_carga_pc),
        .i_valor(w_prox_pc),
        .o_valor(endereco)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado       <= BUSCA;
            r_instrucao    <= '0;
            r_pc_instrucao <= '0;
            r_valida       <= 1'b0;
        end else if (desvio) begin
            r_estado <= BUSCA;
            r_valida <= 1'b0;
        end else if (w_buscando) begin
            r_estado <= (w_livre && w_ultimo) ? PARADO : BUSCA;
            if (w_livre) begin
                r_instrucao    <= instrucao_mem;
                r_pc_instrucao <= endereco;
                r_valida       <= 1'b1;
            end
        end else if (w_transfer) begin
            r_valida <= 1'b0;
        end
    end

    assign instrucao    = r_instrucao;
    assign pc_instrucao = r_pc_instrucao;
    assign valida       = r_valida;
    assign parado       = (r_estado == PARADO) & ~r_valida;
endmodule
